// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute controller for the ALU datapath.
// Reads instructions from a synchronous ROM and holds each in an
// instruction register. Issues a one-cycle exec1 strobe and owns the carry
// flag. Stalls input ops until external data is valid, and executes the
// jump/halt ops that the ALU itself ignores.
module cpu_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            run,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd,
  input  logic [15:0]     imem_data,
  output logic [15:0]     instr,
  output logic            exec1,
  input  logic            carryout,
  input  logic            carryen,
  output logic            carrystatus,
  input  logic            in_valid,
  output logic            in_req,
  output logic            in_ack,
  output logic            halted,
  output logic [PC_W-1:0] pc
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    WAIT_IN = 3'd2,
    EXEC    = 3'd3,
    HALT    = 3'd4
  } state_t;

  // Opcodes in instr[15:8] that the sequencer itself acts on.
  localparam logic [7:0] OP_JMP  = 8'h00;
  localparam logic [7:0] OP_JC   = 8'h01;
  localparam logic [7:0] OP_JNC  = 8'h02;
  localparam logic [7:0] OP_HALT = 8'h03;
  localparam logic [7:0] OP_IN   = 8'hFC;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [15:0]     instr_reg, instr_next;
  logic            carry_reg, carry_next;

  logic [7:0]      exec_op;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] jump_target;

  assign exec_op     = instr_reg[15:8];
  assign pc_inc      = pc_reg + PC_ONE;
  assign jump_target = instr_reg[PC_W-1:0];

  // State, pc, instruction register and carry flag; reset aborts any
  // instruction in flight, so nothing it would have written survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= FETCH;
      pc_reg    <= RESET_PC;
      instr_reg <= 16'h0000;
      carry_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      carry_reg <= carry_next;
    end
  end

  // Next-state logic plus strobes decoded from the state register only,
  // so in_valid never reaches exec1 combinationally.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    carry_next = carry_reg;
    imem_rd    = 1'b0;
    exec1      = 1'b0;
    in_req     = 1'b0;
    in_ack     = 1'b0;
    halted     = 1'b0;

    case (state_reg)
      FETCH: begin
        imem_rd = run;
        if (run) begin
          state_next = DECODE;
        end
      end

      DECODE: begin
        instr_next = imem_data;
        if ((imem_data[15:8] == OP_IN) && !in_valid) begin
          state_next = WAIT_IN;
        end else begin
          state_next = EXEC;
        end
      end

      WAIT_IN: begin
        in_req = 1'b1;
        if (in_valid) begin
          state_next = EXEC;
        end
      end

      EXEC: begin
        exec1      = 1'b1;
        in_ack     = (exec_op == OP_IN);
        state_next = FETCH;
        if (carryen) begin
          carry_next = carryout;
        end
        // Branch conditions use the flag value from before this cycle's update.
        case (exec_op)
          OP_JMP:  pc_next = jump_target;
          OP_JC:   pc_next = carry_reg ? jump_target : pc_inc;
          OP_JNC:  pc_next = carry_reg ? pc_inc : jump_target;
          OP_HALT: begin
            pc_next    = pc_reg;
            state_next = HALT;
          end
          default: pc_next = pc_inc;
        endcase
      end

      HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign instr       = instr_reg;
  assign carrystatus = carry_reg;

endmodule
